mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the byte-addressable data memory (`mem`). It shares the memory between an instruction-fetch requester (port 0) and a load/store requester (port 1). It grants one access at a time, drives the memory's address, data, size and extend controls from a latched request, and returns registered read data. It also rejects misaligned, out-of-range or illegal-size accesses before they reach the array.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_check.sv | 30 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings, FSM states and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] BYTE         = 2'b00;
  localparam logic [1:0] HALF_WORD    = 2'b01;
  localparam logic [1:0] WORD         = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEFAULT_MEM_BYTES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Byte count of an access; the illegal encoding reports zero bytes.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      BYTE:      return 3'd1;
      HALF_WORD: return 3'd2;
      WORD:      return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_check.sv
// Combinational access legality check: illegal size, misalignment and bounds.
module mem_access_check
  import mem_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [1:0]           size,
  output logic                 err
);

  logic [BUS_WIDTH:0] nbytes;
  logic [BUS_WIDTH:0] end_addr;
  logic               illegal_size;
  logic               misaligned;
  logic               out_of_range;

  // One extra bit on the end address so an access near 2^BUS_WIDTH cannot wrap into range.
  always_comb begin
    nbytes       = {{(BUS_WIDTH-2){1'b0}}, size_bytes(size)};
    end_addr     = {1'b0, addr} + nbytes;
    illegal_size = (size == SIZE_ILLEGAL);
    misaligned   = ((size == WORD) && (addr[1:0] != 2'b00)) ||
                   ((size == HALF_WORD) && addr[0]);
    out_of_range = end_addr > (BUS_WIDTH+1)'(MEM_BYTES);
    err          = illegal_size | misaligned | out_of_range;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 1 wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [BUS_WIDTH-1:0] addr0,
  input  logic [BUS_WIDTH-1:0] addr1,
  input  logic [BUS_WIDTH-1:0] wdata0,
  input  logic [BUS_WIDTH-1:0] wdata1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [1:0]           size0,
  input  logic [1:0]           size1,
  input  logic                 sext0,
  input  logic                 sext1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [BUS_WIDTH-1:0] rdata0,
  output logic [BUS_WIDTH-1:0] rdata1,
  output logic                 err0,
  output logic                 err1,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);

  arb_state_t           state;
  logic                 any_req;
  logic                 winner;
  logic                 grant_ok;
  logic [BUS_WIDTH-1:0] sel_addr;
  logic [BUS_WIDTH-1:0] sel_wdata;
  logic [1:0]           sel_size;
  logic                 sel_we;
  logic                 sel_sext;
  logic                 sel_err;

  logic [BUS_WIDTH-1:0] lat_addr;
  logic [BUS_WIDTH-1:0] lat_wdata;
  logic [1:0]           lat_size;
  logic                 lat_we;
  logic                 lat_sext;
  logic                 lat_port;
  logic                 lat_err;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                 last_port;
`endif

  assign any_req = req0 | req1;

  // Tie-break: round-robin favours the port not granted last; fixed priority favours load/store.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    winner = (req0 && req1) ? ~last_port : req1;
`else
    winner = req1;
`endif
  end

  assign sel_addr  = (winner == PORT1) ? addr1  : addr0;
  assign sel_wdata = (winner == PORT1) ? wdata1 : wdata0;
  assign sel_size  = (winner == PORT1) ? size1  : size0;
  assign sel_we    = (winner == PORT1) ? we1    : we0;
  assign sel_sext  = (winner == PORT1) ? sext1  : sext0;

  mem_access_check #(
    .BUS_WIDTH(BUS_WIDTH),
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr(sel_addr),
    .size(sel_size),
    .err (sel_err)
  );

  assign grant_ok = (state == IDLE) && any_req && !rst;
  assign gnt0     = grant_ok && (winner == PORT0);
  assign gnt1     = grant_ok && (winner == PORT1);

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_size  = lat_size;
  assign mem_sz_ex = lat_sext;
  // Reset must block a write even when it lands in the middle of ACCESS.
  assign mem_wr_en = (state == ACCESS) && lat_we && !lat_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= BYTE;
      lat_we    <= 1'b0;
      lat_sext  <= 1'b0;
      lat_port  <= PORT0;
      lat_err   <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_port <= PORT1;
`endif
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_size  <= sel_size;
            lat_we    <= sel_we;
            lat_sext  <= sel_sext;
            lat_port  <= winner;
            lat_err   <= sel_err;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_port <= winner;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_port == PORT1) begin
            rdata1  <= lat_err ? '0 : mem_rdata;
            err1    <= lat_err;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= lat_err ? '0 : mem_rdata;
            err0    <= lat_err;
            rvalid0 <= 1'b1;
          end
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural byte memory attached.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;
  localparam logic [1:0] SZ_XX = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, sext0, sext1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr_en, mem_sz_ex;
  logic [1:0]  mem_size;

  typedef struct {
    logic        sb_port;
    logic [31:0] sb_rdata;
    logic        sb_err;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          tests = 0;
  int          fails = 0;

  logic [7:0]  mem_arr[256];
  logic [7:0]  exp_mem[256];
  logic        mem_loaded = 1'b0;
  logic [31:0] last_rdata[2];
  logic        last_err[2];
  sb_entry_t   mon_e;
  logic        mon_p;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .sext0(sext0), .sext1(sext1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_size(mem_size), .mem_sz_ex(mem_sz_ex), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory: combinational read with extension, write at the clock edge.
  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    mem_rdata = '0;
    case (mem_size)
      SZ_B: mem_rdata = mem_sz_ex ? {{24{mem_arr[a][7]}}, mem_arr[a]} : {24'b0, mem_arr[a]};
      SZ_H: mem_rdata = mem_sz_ex ? {{16{mem_arr[a+8'd1][7]}}, mem_arr[a+8'd1], mem_arr[a]}
                                  : {16'b0, mem_arr[a+8'd1], mem_arr[a]};
      SZ_W: mem_rdata = {mem_arr[a+8'd3], mem_arr[a+8'd2], mem_arr[a+8'd1], mem_arr[a]};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i * 37 + 5);
      mem_loaded <= 1'b1;
    end else if (mem_wr_en) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_size != SZ_B) mem_arr[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_size == SZ_W) begin
        mem_arr[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        mem_arr[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
    logic [63:0] n;
    n = (s == SZ_B) ? 64'd1 : (s == SZ_H) ? 64'd2 : 64'd4;
    if (s == SZ_XX) return 1'b1;
    if (s == SZ_W && a[1:0] != 2'b00) return 1'b1;
    if (s == SZ_H && a[0]) return 1'b1;
    return ({32'b0, a} + n) > 64'd256;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a32, input logic [1:0] s, input logic x);
    logic [7:0]  a;
    logic [15:0] h;
    a = a32[7:0];
    h = {exp_mem[a+8'd1], exp_mem[a]};
    case (s)
      SZ_B:    return x ? {{24{exp_mem[a][7]}}, exp_mem[a]} : {24'b0, exp_mem[a]};
      SZ_H:    return x ? {{16{h[15]}}, h} : {16'b0, h};
      SZ_W:    return {exp_mem[a+8'd3], exp_mem[a+8'd2], h};
      default: return 32'b0;
    endcase
  endfunction

  task automatic ref_write(input logic [31:0] a32, input logic [1:0] s, input logic [31:0] d);
    logic [7:0] a;
    a = a32[7:0];
    exp_mem[a] = d[7:0];
    if (s != SZ_B) exp_mem[a+8'd1] = d[15:8];
    if (s == SZ_W) begin
      exp_mem[a+8'd2] = d[23:16];
      exp_mem[a+8'd3] = d[31:24];
    end
  endtask

  // Response monitor: every rvalid pops one expectation; the idle port must hold its outputs.
  always @(negedge clk) begin
    if (rst) begin
      last_rdata[0] = '0; last_rdata[1] = '0;
      last_err[0]   = 1'b0; last_err[1] = 1'b0;
    end else if (rvalid0 || rvalid1) begin
      check_output("rvalid_onehot", {31'b0, rvalid0 & rvalid1}, 32'd0);
      check_output("sb_has_entry", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        mon_p = rvalid1;
        check_output("rvalid_port", {31'b0, mon_p}, {31'b0, mon_e.sb_port});
        check_output("rdata", mon_p ? rdata1 : rdata0, mon_e.sb_rdata);
        check_output("err", {31'b0, mon_p ? err1 : err0}, {31'b0, mon_e.sb_err});
        check_output("other_rdata_hold", mon_p ? rdata0 : rdata1, last_rdata[~mon_p]);
        check_output("other_err_hold", {31'b0, mon_p ? err0 : err1}, {31'b0, last_err[~mon_p]});
        last_rdata[mon_p] = mon_e.sb_rdata;
        last_err[mon_p]   = mon_e.sb_err;
      end
    end
  end

  // One complete access on a single port, called just after a rising edge.
  task automatic apply_stimulus(input logic port, input logic we, input logic [1:0] size,
                                input logic sext, input logic [31:0] addr,
                                input logic [31:0] wdata, output int waited);
    logic      granted;
    logic      e_err;
    sb_entry_t e;
    if (port) begin
      req1 = 1'b1; we1 = we; size1 = size; sext1 = sext; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; size0 = size; sext0 = sext; addr0 = addr; wdata0 = wdata;
    end
    waited = 0;
    @(negedge clk);
    while (!(port ? gnt1 : gnt0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    granted = port ? gnt1 : gnt0;
    check_output("gnt", {31'b0, granted}, 32'd1);
    e_err = ref_err(addr, size);
    if (granted) begin
      e.sb_port  = port;
      e.sb_err   = e_err;
      e.sb_rdata = e_err ? 32'b0 : ref_read(addr, size, sext);
      sb_q.push_back(e);
      if (we && !e_err) ref_write(addr, size, wdata);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (granted) begin
      @(negedge clk);
      check_output("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, we & ~e_err});
      check_output("mem_addr", mem_addr, addr);
      @(negedge clk);
      check_output("rvalid_latency", {31'b0, port ? rvalid1 : rvalid0}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  w;
    int  exp_port;
    sb_entry_t e;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 37 + 5);
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; size0 = SZ_W; sext0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; size1 = SZ_W; sext1 = 1'b0; addr1 = 32'h4; wdata1 = 32'h0;

    // Reset held with both requests high.
    repeat (2) begin
      @(negedge clk);
      check_output("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
      check_output("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
      check_output("rst_err", {30'b0, err1, err0}, 32'd0);
      check_output("rst_rdata0", rdata0, 32'd0);
      check_output("rst_rdata1", rdata1, 32'd0);
      check_output("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
      check_output("rst_mem_addr", mem_addr, 32'd0);
      check_output("rst_mem_wdata", mem_wdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requests held continuously.
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      w = 0;
      while (!(gnt0 || gnt1) && w < 10) begin
        @(negedge clk);
        w++;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_port = g % 2;
`else
      exp_port = 1;
`endif
      check_output("tie_any_gnt", {31'b0, gnt0 | gnt1}, 32'd1);
      check_output("tie_gnt_onehot", {31'b0, gnt0 & gnt1}, 32'd0);
      check_output("tie_winner", {31'b0, gnt1}, 32'(exp_port));
      if (g > 0) check_output("tie_spacing", 32'(w), 32'd2);
      e.sb_port  = exp_port[0];
      e.sb_err   = 1'b0;
      e.sb_rdata = ref_read(exp_port[0] ? 32'h4 : 32'h0, SZ_W, 1'b0);
      sb_q.push_back(e);
      @(posedge clk);
      if (g == 5) begin
        #1;
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Write then sign-extended byte read on port 1.
    apply_stimulus(1'b1, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, w);
    apply_stimulus(1'b1, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, w);
    check_output("sext_byte_literal", rdata1, 32'hFFFFFFDE);
    apply_stimulus(1'b0, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, w);
    check_output("zext_byte_literal", rdata0, 32'h000000BE);

    // Misaligned write must be dropped.
    apply_stimulus(1'b1, 1'b1, SZ_W, 1'b0, 32'h02, 32'h11223344, w);
    check_output("misaligned_err", {31'b0, err1}, 32'd1);
    apply_stimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, w);

    // Bounds and illegal size.
    apply_stimulus(1'b0, 1'b0, SZ_W, 1'b0, 32'hFD, 32'h0, w);
    check_output("bound_fd", {31'b0, err0}, 32'd1);
    apply_stimulus(1'b0, 1'b0, SZ_W, 1'b0, 32'hFC, 32'h0, w);
    check_output("bound_fc", {31'b0, err0}, 32'd0);
    apply_stimulus(1'b0, 1'b0, SZ_H, 1'b0, 32'hFF, 32'h0, w);
    check_output("bound_ff_half", {31'b0, err0}, 32'd1);
    apply_stimulus(1'b1, 1'b0, SZ_XX, 1'b0, 32'h00, 32'h0, w);
    check_output("size_illegal", {31'b0, err1}, 32'd1);
    apply_stimulus(1'b0, 1'b0, SZ_H, 1'b1, 32'hFE, 32'h0, w);
    apply_stimulus(1'b0, 1'b1, SZ_H, 1'b0, 32'h40, 32'h0000A55A, w);
    apply_stimulus(1'b0, 1'b0, SZ_H, 1'b1, 32'h40, 32'h0, w);
    apply_stimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, w);
    apply_stimulus(1'b1, 1'b1, SZ_B, 1'b0, 32'h100, 32'h77, w);
    check_output("bound_100_byte", {31'b0, err1}, 32'd1);

    // Reset during ACCESS of a port-0 write.
    req0 = 1'b1; we0 = 1'b1; size0 = SZ_W; sext0 = 1'b0; addr0 = 32'h20; wdata0 = 32'h12345678;
    @(negedge clk);
    check_output("rst_mid_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check_output("rst_mid_wr_en", {31'b0, mem_wr_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, w);
    check_output("idle_after_rst", 32'(w), 32'd0);

    repeat (3) @(negedge clk);
    check_output("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
